// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller for the CNN layer chain: feeds one n x n frame, counts chain outputs, reports done/timeout.
// Optional CNN_FRAME_PERF_EN adds o_perf_cycles / o_perf_stall performance counters.
module cnn_frame_sequencer #(
   parameter int unsigned NUM_LAYERS    = 3,
   parameter int unsigned DATA_WIDTH    = 20,
   parameter int unsigned n             = 480,
   parameter int unsigned K             = 3,
   parameter int unsigned p             = 2,
   parameter int unsigned P             = 1,
   parameter int unsigned DRAIN_TIMEOUT = 4096
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [7:0]            i_s_pixel,
   input  logic                  i_s_valid,
   output logic                  o_s_ready,
   output logic [7:0]            o_cnn_pixel,
   output logic                  o_cnn_ce,
   output logic                  o_cnn_clear,
   input  logic                  i_cnn_valid,
   input  logic [DATA_WIDTH-1:0] i_cnn_data,
   output logic [DATA_WIDTH-1:0] o_m_data,
   output logic                  o_m_valid,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic                  o_err_timeout,
   output logic [31:0]           o_out_count
`ifdef CNN_FRAME_PERF_EN
   ,
   output logic [31:0]           o_perf_cycles,
   output logic [31:0]           o_perf_stall
`endif
);

   function automatic int unsigned f_out_dim();
      int unsigned m;
      m = n;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) m = (m + 2 * P + 1 - K) / p;
      return m;
   endfunction

   localparam int unsigned OUT_DIM  = f_out_dim();
   localparam int unsigned EXP_OUT  = OUT_DIM * OUT_DIM;
   localparam int unsigned IN_TOTAL = n * n;
   localparam int unsigned TO_W     = $clog2(DRAIN_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE, S_ABORT
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [31:0]           r_pix_cnt;
   logic [31:0]           r_out_count;
   logic [TO_W-1:0]       r_to_cnt;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_m_data;
   logic                  r_m_valid;
   logic                  w_start_acc;
   logic                  w_to_hit;
   logic                  w_capture;
   logic [31:0]           w_out_cnt_inc;

   // Chain outputs are only meaningful while a frame is being fed or drained
   assign w_capture     = i_cnn_valid && ((r_state == S_FEED) || (r_state == S_DRAIN));
   assign w_out_cnt_inc = r_out_count + 32'(w_capture);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_start_acc  = 1'b0;
      w_to_hit     = 1'b0;
      o_s_ready    = 1'b0;
      o_cnn_ce     = 1'b0;
      o_cnn_pixel  = 8'd0;
      o_cnn_clear  = 1'b0;
      o_frame_done = 1'b0;
      o_busy       = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_start_acc = 1'b1;
               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            o_cnn_clear = 1'b1;
            w_state_nxt = i_abort ? S_ABORT : S_FEED;
         end
         S_FEED: begin
            o_s_ready = 1'b1;
            if (i_s_valid) begin
               o_cnn_ce    = 1'b1;
               o_cnn_pixel = i_s_pixel;
            end
            // Abort outranks the final pixel handshake
            if (i_abort)
               w_state_nxt = S_ABORT;
            else if (i_s_valid && (r_pix_cnt == 32'(IN_TOTAL - 1)))
               w_state_nxt = (w_out_cnt_inc >= 32'(EXP_OUT)) ? S_DONE : S_DRAIN;
         end
         S_DRAIN: begin
            if (i_abort)
               w_state_nxt = S_ABORT;
            else if (w_out_cnt_inc >= 32'(EXP_OUT))
               w_state_nxt = S_DONE;
            else if (!i_cnn_valid && (r_to_cnt == TO_W'(DRAIN_TIMEOUT - 1))) begin
               w_to_hit    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            o_frame_done = 1'b1;
            w_state_nxt  = S_IDLE;
         end
         S_ABORT: begin
            o_cnn_clear = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pix_cnt   <= 32'd0;
         r_out_count <= 32'd0;
         r_to_cnt    <= '0;
         r_err       <= 1'b0;
         r_m_data    <= '0;
         r_m_valid   <= 1'b0;
      end else begin
         r_m_valid <= w_capture;
         if (w_capture) r_m_data <= i_cnn_data;
         if (w_start_acc) begin
            r_pix_cnt   <= 32'd0;
            r_out_count <= 32'd0;
            r_to_cnt    <= '0;
            r_err       <= 1'b0;
         end else begin
            if (o_cnn_ce)  r_pix_cnt   <= r_pix_cnt + 32'd1;
            if (w_capture) r_out_count <= w_out_cnt_inc;
            if ((r_state == S_DRAIN) && !i_cnn_valid) r_to_cnt <= r_to_cnt + TO_W'(1);
            else                                      r_to_cnt <= '0;
            if (w_to_hit) r_err <= 1'b1;
         end
      end
   end

   assign o_m_data      = r_m_data;
   assign o_m_valid     = r_m_valid;
   assign o_err_timeout = r_err;
   assign o_out_count   = r_out_count;

`ifdef CNN_FRAME_PERF_EN
   logic [31:0] r_perf_cycles;
   logic [31:0] r_perf_stall;

   // Cycle count spans CLEAR entry to DONE entry; both hold until the next start
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_perf_cycles <= 32'd0;
         r_perf_stall  <= 32'd0;
      end else if (w_start_acc) begin
         r_perf_cycles <= 32'd0;
         r_perf_stall  <= 32'd0;
      end else begin
         if ((r_state == S_CLEAR) || (r_state == S_FEED) || (r_state == S_DRAIN))
            r_perf_cycles <= r_perf_cycles + 32'd1;
         if ((r_state == S_FEED) && !i_s_valid)
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign o_perf_cycles = r_perf_cycles;
   assign o_perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed self-checking bench for cnn_frame_sequencer with a small delayed-output chain model.
// Set CNN_FRAME_PERF_EN to also check the performance counters.
module tb_cnn_frame_sequencer;
   localparam int unsigned DW = 20;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, abort, s_valid, s_ready;
   logic [7:0]    s_pixel, cnn_pixel;
   logic          cnn_ce, cnn_clear, cnn_valid, m_valid, busy, frame_done, err_timeout;
   logic [DW-1:0] cnn_data, m_data;
   logic [31:0]   out_count;
`ifdef CNN_FRAME_PERF_EN
   logic [31:0]   perf_cycles, perf_stall, d_perf_cycles, d_perf_stall;
`endif

   always #5 clk = ~clk;

   cnn_frame_sequencer #(
      .NUM_LAYERS(1), .DATA_WIDTH(DW), .n(8), .K(3), .p(2), .P(1), .DRAIN_TIMEOUT(64)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
      .i_s_pixel(s_pixel), .i_s_valid(s_valid), .o_s_ready(s_ready),
      .o_cnn_pixel(cnn_pixel), .o_cnn_ce(cnn_ce), .o_cnn_clear(cnn_clear),
      .i_cnn_valid(cnn_valid), .i_cnn_data(cnn_data),
      .o_m_data(m_data), .o_m_valid(m_valid), .o_busy(busy), .o_frame_done(frame_done),
      .o_err_timeout(err_timeout), .o_out_count(out_count)
`ifdef CNN_FRAME_PERF_EN
      , .o_perf_cycles(perf_cycles), .o_perf_stall(perf_stall)
`endif
   );

   // Default-parameter instance, idle, used for elaboration constants only
   logic          d_s_ready, d_cnn_ce, d_cnn_clear, d_m_valid, d_busy, d_frame_done, d_err;
   logic [7:0]    d_cnn_pixel;
   logic [19:0]   d_m_data;
   logic [31:0]   d_out_count;
   cnn_frame_sequencer dut_def (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(1'b0), .i_abort(1'b0),
      .i_s_pixel(8'd0), .i_s_valid(1'b0), .o_s_ready(d_s_ready),
      .o_cnn_pixel(d_cnn_pixel), .o_cnn_ce(d_cnn_ce), .o_cnn_clear(d_cnn_clear),
      .i_cnn_valid(1'b0), .i_cnn_data(20'd0),
      .o_m_data(d_m_data), .o_m_valid(d_m_valid), .o_busy(d_busy), .o_frame_done(d_frame_done),
      .o_err_timeout(d_err), .o_out_count(d_out_count)
`ifdef CNN_FRAME_PERF_EN
      , .o_perf_cycles(d_perf_cycles), .o_perf_stall(d_perf_stall)
`endif
   );

   // Chain model: every 4th accepted pixel yields one output 3 cycles later, up to m_limit
   int            m_idx, m_emit, m_limit;
   logic [2:0]    m_v;
   logic [DW-1:0] m_d0, m_d1, m_d2;
   logic          m_fire;
   assign m_fire    = cnn_ce && (m_idx % 4 == 3) && (m_emit < m_limit);
   assign cnn_valid = m_v[2];
   assign cnn_data  = m_d2;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || cnn_clear) begin
         m_idx <= 0; m_emit <= 0; m_v <= '0; m_d0 <= '0; m_d1 <= '0; m_d2 <= '0;
      end else begin
         m_v  <= {m_v[1:0], m_fire};
         m_d1 <= m_d0;
         m_d2 <= m_d1;
         if (cnn_ce) m_idx <= m_idx + 1;
         if (m_fire) begin
            m_d0   <= DW'(m_emit * 37 + 5);
            m_emit <= m_emit + 1;
         end
      end
   end

   // Monitor sampled on the falling edge
   int            cyc, n_ce, n_clear, n_done, n_ready, n_mv, n_lat, n_pix, fidx;
   int            cyc_done, cyc_last_cv, cyc_last_ce;
   logic          prev_cv = 1'b0;
   logic [DW-1:0] prev_cd = '0;
   initial begin
      cyc = 0; n_ce = 0; n_clear = 0; n_done = 0; n_ready = 0; n_mv = 0; n_lat = 0; n_pix = 0;
      fidx = 0; cyc_done = 0; cyc_last_cv = 0; cyc_last_ce = 0;
   end
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (cnn_clear) begin n_clear = n_clear + 1; fidx = 0; end
      if (cnn_ce) begin
         if (cnn_pixel !== 8'(fidx)) n_pix = n_pix + 1;
         fidx = fidx + 1; n_ce = n_ce + 1; cyc_last_ce = cyc;
      end
      if (frame_done) begin n_done = n_done + 1; cyc_done = cyc; end
      if (s_ready) n_ready = n_ready + 1;
      if (m_valid) begin
         n_mv = n_mv + 1;
         if (!(prev_cv && (m_data === prev_cd))) n_lat = n_lat + 1;
      end
      if (cnn_valid) cyc_last_cv = cyc;
      prev_cv = cnn_valid;
      prev_cd = cnn_data;
   end

   int checks = 0, failures = 0;
   int b_ce, b_clear, b_done, b_ready, b_mv, b_lat, b_pix;

   task automatic snap();
      b_ce = n_ce; b_clear = n_clear; b_done = n_done; b_ready = n_ready;
      b_mv = n_mv; b_lat = n_lat; b_pix = n_pix;
   endtask

   task automatic feed(input bit gap, input int npix);
      int sent = 0, guard = 0;
      bit tog = 1'b1, hs, rdy;
      while (sent < npix && guard < 600) begin
         s_valid = gap ? tog : 1'b1;
         s_pixel = 8'(sent);
         hs  = s_valid && s_ready;
         rdy = s_ready;
         @(posedge clk); #1;
         if (hs) sent++;
         if (rdy) tog = !tog;
         guard++;
      end
      checks++; if (sent != npix) begin failures++; $display("FAIL feed_handshakes got=%0d exp=%0d", sent, npix); end
   endtask

   task automatic run_frame(input bit gap, input int limit, input bit hold_start);
      int g = 0;
      snap();
      m_limit = limit;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 if (!hold_start) start = 1'b0;
      feed(gap, 64);
      s_valid = 1'b0;
      start   = 1'b0;
      while (n_done == b_done && g < 300) begin @(posedge clk); #1; g++; end
      checks++; if (g >= 300) begin failures++; $display("FAIL frame_done_wait got=timeout exp=pulse"); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      checks++; if ({s_ready, cnn_ce, cnn_clear, m_valid, busy, frame_done, err_timeout} !== 7'd0)
         begin failures++; $display("FAIL reset_flags got=%b exp=0", {s_ready, cnn_ce, cnn_clear, m_valid, busy, frame_done, err_timeout}); end
      checks++; if (m_data !== '0 || out_count !== 32'd0)
         begin failures++; $display("FAIL reset_data got=%0d/%0d exp=0/0", m_data, out_count); end
   endtask

   task automatic test_full_frame();
      run_frame(1'b0, 16, 1'b0);
      checks++; if (n_clear - b_clear != 1) begin failures++; $display("FAIL full_clear got=%0d exp=1", n_clear - b_clear); end
      checks++; if (n_ce - b_ce != 64) begin failures++; $display("FAIL full_ce got=%0d exp=64", n_ce - b_ce); end
      checks++; if (n_ready - b_ready != 64) begin failures++; $display("FAIL full_ready got=%0d exp=64", n_ready - b_ready); end
      checks++; if (n_mv - b_mv != 16) begin failures++; $display("FAIL full_mvalid got=%0d exp=16", n_mv - b_mv); end
      checks++; if (n_lat != b_lat) begin failures++; $display("FAIL full_latency got=%0d exp=0", n_lat - b_lat); end
      checks++; if (n_pix != b_pix) begin failures++; $display("FAIL full_pixel got=%0d exp=0", n_pix - b_pix); end
      checks++; if (n_done - b_done != 1) begin failures++; $display("FAIL full_done got=%0d exp=1", n_done - b_done); end
      checks++; if (cyc_done != cyc_last_cv + 1) begin failures++; $display("FAIL full_done_lat got=%0d exp=1", cyc_done - cyc_last_cv); end
      checks++; if (out_count !== 32'd16) begin failures++; $display("FAIL full_out_count got=%0d exp=16", out_count); end
      checks++; if (m_data !== DW'(15 * 37 + 5)) begin failures++; $display("FAIL full_last_data got=%0d exp=%0d", m_data, 15 * 37 + 5); end
      checks++; if (busy !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL full_idle got=%b%b exp=00", busy, err_timeout); end
`ifdef CNN_FRAME_PERF_EN
      checks++; if (perf_cycles !== 32'd68) begin failures++; $display("FAIL full_perf_cycles got=%0d exp=68", perf_cycles); end
      checks++; if (perf_stall !== 32'd0) begin failures++; $display("FAIL full_perf_stall got=%0d exp=0", perf_stall); end
`endif
   endtask

   task automatic test_stall_toggle();
      run_frame(1'b1, 16, 1'b0);
      checks++; if (n_ce - b_ce != 64) begin failures++; $display("FAIL stall_ce got=%0d exp=64", n_ce - b_ce); end
      checks++; if (n_ready - b_ready != 127) begin failures++; $display("FAIL stall_ready got=%0d exp=127", n_ready - b_ready); end
      checks++; if (n_pix != b_pix) begin failures++; $display("FAIL stall_pixel got=%0d exp=0", n_pix - b_pix); end
      checks++; if (out_count !== 32'd16) begin failures++; $display("FAIL stall_out_count got=%0d exp=16", out_count); end
`ifdef CNN_FRAME_PERF_EN
      checks++; if (perf_stall !== 32'd63) begin failures++; $display("FAIL stall_perf_stall got=%0d exp=63", perf_stall); end
      checks++; if (perf_cycles !== 32'd131) begin failures++; $display("FAIL stall_perf_cycles got=%0d exp=131", perf_cycles); end
`endif
   endtask

   task automatic test_timeout();
      run_frame(1'b0, 10, 1'b0);
      checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", err_timeout); end
      checks++; if (out_count !== 32'd10) begin failures++; $display("FAIL to_out_count got=%0d exp=10", out_count); end
      checks++; if (n_done - b_done != 1) begin failures++; $display("FAIL to_done got=%0d exp=1", n_done - b_done); end
      checks++; if (cyc_done - cyc_last_ce != 65) begin failures++; $display("FAIL to_done_lat got=%0d exp=65", cyc_done - cyc_last_ce); end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      checks++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_restart got=%b%b exp=01", err_timeout, busy); end
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      m_limit = 16;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      feed(1'b0, 30);
      snap();
      s_valid = 1'b0;
      abort   = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      checks++; if (cnn_clear !== 1'b1) begin failures++; $display("FAIL abort_clear got=%b exp=1", cnn_clear); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || cnn_clear !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b%b exp=00", busy, cnn_clear); end
      abort = 1'b1;
      repeat (4) @(posedge clk);
      #1 abort = 1'b0;
      checks++; if (n_done != b_done || n_clear - b_clear != 1) begin failures++; $display("FAIL abort_no_done got=%0d/%0d exp=0/1", n_done - b_done, n_clear - b_clear); end
      run_frame(1'b0, 16, 1'b0);
      checks++; if (out_count !== 32'd16 || n_mv - b_mv != 16) begin failures++; $display("FAIL abort_next got=%0d/%0d exp=16/16", out_count, n_mv - b_mv); end
   endtask

   task automatic test_async_reset_start_busy();
      m_limit = 16;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      feed(1'b0, 20);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({s_ready, cnn_ce, cnn_clear, m_valid, busy, frame_done, err_timeout} !== 7'd0)
         begin failures++; $display("FAIL arst_flags got=%b exp=0", {s_ready, cnn_ce, cnn_clear, m_valid, busy, frame_done, err_timeout}); end
      checks++; if (m_data !== '0 || out_count !== 32'd0) begin failures++; $display("FAIL arst_data got=%0d/%0d exp=0/0", m_data, out_count); end
      s_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      run_frame(1'b0, 16, 1'b1);
      checks++; if (n_clear - b_clear != 1 || n_done - b_done != 1) begin failures++; $display("FAIL busy_start got=%0d/%0d exp=1/1", n_clear - b_clear, n_done - b_done); end
      checks++; if (out_count !== 32'd16 || n_ce - b_ce != 64) begin failures++; $display("FAIL busy_counts got=%0d/%0d exp=16/64", out_count, n_ce - b_ce); end
   endtask

   task automatic test_default_params();
      int unsigned exp_out, in_total;
      exp_out  = dut_def.EXP_OUT;
      in_total = dut_def.IN_TOTAL;
      checks++; if (exp_out != 32'd3600) begin failures++; $display("FAIL def_exp_out got=%0d exp=3600", exp_out); end
      checks++; if (in_total != 32'd230400) begin failures++; $display("FAIL def_in_total got=%0d exp=230400", in_total); end
      checks++; if (d_busy !== 1'b0 || d_out_count !== 32'd0) begin failures++; $display("FAIL def_idle got=%b/%0d exp=0/0", d_busy, d_out_count); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_pixel = 8'd0; m_limit = 16;
      #12;
      test_reset();
      rst_n = 1'b1;
      test_full_frame();
      test_stall_toggle();
      test_timeout();
      test_abort();
      test_async_reset_start_busy();
      test_default_params();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
- Frame-level controller in front of the multilayer CNN layer chain.
- Accepts one n×n frame of 8-bit pixels over a valid/ready stream and drives the chain's pixel and ce inputs.
- Counts the chain's valid outputs against a count computed at elaboration, then reports frame completion, errors and status.
- One frame in flight at a time; clears the chain before every frame.

Parameters:
- NUM_LAYERS, 3, number of conv+pool layers in the controlled chain
- DATA_WIDTH, 20, width of chain output samples
- n, 480, input frame edge length in pixels
- K, 3, kernel edge length
- p, 2, pooling factor
- P, 1, zero padding per side
- DRAIN_TIMEOUT, 4096, max cycles in DRAIN without a chain valid before error

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  cancel the current frame
- s_pixel  in  8  input pixel
- s_valid  in  1  input pixel valid
- s_ready  out  1  sequencer accepts pixel
- cnn_pixel  out  8  pixel to chain
- cnn_ce  out  1  chain clock enable / input valid
- cnn_clear  out  1  one-cycle synchronous clear pulse to chain
- cnn_valid  in  1  chain final_valid
- cnn_data  in  DATA_WIDTH  chain final_output
- m_data  out  DATA_WIDTH  registered output sample
- m_valid  out  1  output sample valid (no backpressure)
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- err_timeout  out  1  sticky error flag; cleared on next accepted start
- out_count  out  32  outputs received in current/last frame

Behaviour:
- Reset: state=IDLE. All outputs 0: s_ready, cnn_ce, cnn_clear, m_valid, m_data, busy, frame_done, err_timeout, out_count. Pixel and output counters also 0.
- Localparam OUT_DIM: start from n, apply m=(m+2P-K+1)/p once per layer (integer divide). EXP_OUT=OUT_DIM². Defaults give 480→240→120→60, EXP_OUT=3600. IN_TOTAL=n².
- IDLE: start=1 → CLEAR. Same edge: clear counters, clear err_timeout, set busy.
- CLEAR: cnn_clear=1 for exactly one cycle → FEED.
- FEED: s_ready=1. Handshake is s_valid&s_ready; on it, cnn_ce=1 and cnn_pixel=s_pixel, combinational pass-through with zero latency. Stall (s_valid=0) gives cnn_ce=0 and the chain holds. The pixel counter increments per handshake; on the IN_TOTAL-th handshake → DRAIN, and s_ready drops the next cycle.
- DRAIN: s_ready=0, cnn_ce=0. Timeout counter resets on every cnn_valid and otherwise increments. Reaching DRAIN_TIMEOUT sets err_timeout → DONE.
- Output capture, active in FEED and DRAIN: cnn_valid registers into m_data/m_valid with 1-cycle latency and out_count+1. If out_count reaches EXP_OUT in DRAIN → DONE. If it reaches EXP_OUT in FEED, stay in FEED and go to DONE when pixels complete. Outputs beyond EXP_OUT are still forwarded and counted; no error.
- DONE: frame_done=1 for one cycle → IDLE. out_count holds until the next start.
- cnn_valid in IDLE/CLEAR/DONE is ignored: m_valid=0, no count.
- abort in CLEAR/FEED/DRAIN → ABORT. ABORT drives cnn_clear=1 for one cycle → IDLE, with no frame_done. abort has priority over a simultaneous last-pixel handshake or timeout. abort in IDLE/DONE is ignored.
- start while busy is ignored. start and abort together in IDLE: start wins.
- Asynchronous reset mid-frame returns to reset values immediately; no cnn_clear is issued (the chain shares the reset).

Optional Feature:
- Macro CNN_FRAME_PERF_EN.
- Defined: adds output perf_cycles[31:0], which counts cycles from CLEAR entry to DONE entry and holds until the next start. Adds output perf_stall[31:0], which counts FEED cycles with s_valid=0. Both reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- NUM_LAYERS=1, n=8, DRAIN_TIMEOUT=64. Start, stream 64 pixels with s_valid held high; model emits 16 cnn_valid → exactly one cnn_clear pulse after start, 64 cnn_ce cycles, s_ready low after pixel 64, m_valid 16 times with 1-cycle latency, frame_done one cycle after the 16th output, out_count=16.
- Same config, s_valid toggled every other cycle → cnn_ce only on handshakes, still 64 total, same result; with perf enabled, perf_stall=63.
- Same config, model emits only 10 outputs → err_timeout=1 after 64 idle DRAIN cycles, frame_done pulses, out_count=10. Next start clears err_timeout.
- abort asserted after pixel 30 → cnn_clear pulse, IDLE next cycle, busy=0, no frame_done. A following start runs a clean frame with out_count=16.
- reset driven low mid-FEED between clock edges → all outputs 0 asynchronously, state IDLE. start during busy → no effect on counts.
- Default parameters → EXP_OUT elaborates to 3600 and IN_TOTAL to 230400. Full frame completes with frame_done and out_count=3600.
